// File: rtl/enabled_pipe_controller.sv
// enabled_pipe_controller: valid-bit/flow-control sequencer that drives the shared clkEn of a stallable datapath
//   clk, rst                  clock, async active-high reset
//   inValid/inReady           upstream handshake (inReady low in reset, drain, stall or flushReq)
//   outValid/outReady         downstream handshake, outValid is the last stage valid bit
//   clkEn                     enable for every datapath stage, low only under output backpressure
//   occupancy                 items in flight
//   flushReq/draining/flushDone  drain request, drain-in-progress, one-cycle completion pulse
//   stallCount                saturating count of backpressure cycles
module enabled_pipe_controller #(
  parameter int CYCLES = 4,
  parameter int STALL_W = 32,
  localparam int OCC_W = $clog2(CYCLES + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               inValid,
  output logic               inReady,
  output logic               outValid,
  input  logic               outReady,
  output logic               clkEn,
  output logic [OCC_W-1:0]   occupancy,
  input  logic               flushReq,
  output logic               draining,
  output logic               flushDone,
  output logic [STALL_W-1:0] stallCount
);
  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;
  if (CYCLES < 1 || CYCLES > 64) begin : g_bad_cycles
    $error("enabled_pipe_controller: CYCLES must be in 1..64");
  end
  state_t              r_state, w_next;
  logic [CYCLES-1:0]   r_v;
  logic [OCC_W-1:0]    r_occ;
  logic [STALL_W-1:0]  r_stall;
  logic                w_accept, w_pop, w_last;
  assign outValid   = r_v[CYCLES-1];
  assign clkEn      = ~outValid | outReady;
  // flushReq blocks acceptance in the very cycle it is seen
  assign inReady    = clkEn & (r_state == RUN) & ~flushReq & ~rst;
  assign w_accept   = inValid & inReady;
  assign w_pop      = outValid & outReady;
  assign occupancy  = r_occ;
  assign stallCount = r_stall;
  assign draining   = r_state == DRAIN;
  assign flushDone  = r_state == DONE;
  // drain finishes once nothing is left, counting the item leaving this cycle
  assign w_last     = (r_occ == '0) | ((r_occ == OCC_W'(1)) & w_pop);
  always_comb begin
    w_next = (r_state == RUN) ? (flushReq ? DRAIN : RUN) : (r_state == DRAIN) ? (w_last ? DONE : DRAIN) : RUN;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= RUN;
    else r_state <= w_next;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v     <= '0;
      r_occ   <= '0;
      r_stall <= '0;
    end else begin
      // bubbles are shifted along with items and frozen in place on a stall
      if (clkEn) r_v <= (r_v << 1) | CYCLES'(w_accept);
      r_occ <= r_occ + OCC_W'(w_accept) - OCC_W'(w_pop);
      if (outValid & ~outReady & ~&r_stall) r_stall <= r_stall + STALL_W'(1);
    end
  end
  a_occ_matches_valid: assert property (@(posedge clk) disable iff (rst) r_occ == OCC_W'($countones(r_v)));
endmodule

// File: tb/tb_enabled_pipe_controller.sv
// tb_enabled_pipe_controller: directed checks of the pipe controller with a bench-side payload pipe
module tb_enabled_pipe_controller;
  logic clk = 0, rst = 1;
  logic inValid = 0, outReady = 1, flushReq = 0;
  logic inReady, outValid, clkEn, draining, flushDone;
  logic [2:0] occupancy;
  logic [31:0] stallCount;
  logic s_inReady, s_outValid, s_clkEn, s_draining, s_flushDone;
  logic s_occ;
  logic [1:0] s_stall;
  logic [7:0] next_in = 1, exp_out = 1;
  logic [3:0][7:0] pd = '0;
  int n_err = 0, n_chk = 0, npop, first, peak, nd, nf;
  always #5 clk = ~clk;
  enabled_pipe_controller #(.CYCLES(4)) u_dut (
    .clk(clk), .rst(rst), .inValid(inValid), .inReady(inReady), .outValid(outValid),
    .outReady(outReady), .clkEn(clkEn), .occupancy(occupancy), .flushReq(flushReq),
    .draining(draining), .flushDone(flushDone), .stallCount(stallCount)
  );
  enabled_pipe_controller #(.CYCLES(1), .STALL_W(2)) u_sat (
    .clk(clk), .rst(rst), .inValid(1'b1), .inReady(s_inReady), .outValid(s_outValid),
    .outReady(1'b0), .clkEn(s_clkEn), .occupancy(s_occ), .flushReq(1'b0),
    .draining(s_draining), .flushDone(s_flushDone), .stallCount(s_stall)
  );
  always @(posedge clk) if (clkEn) pd <= {pd[2:0], next_in};
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic cyc();
    logic a;
    #1;
    a = inValid && inReady;
    if (outValid && outReady) begin
      chk("order", pd[3], exp_out);
      exp_out++;
      npop++;
    end
    @(posedge clk);
    #2;
    if (a) next_in++;
  endtask
  initial begin
    #3;
    chk("rst_outValid", outValid, 0);
    chk("rst_occ", occupancy, 0);
    chk("rst_clkEn", clkEn, 1);
    chk("rst_inReady", inReady, 0);
    chk("rst_stall", stallCount, 0);
    chk("rst_flushDone", flushDone, 0);
    #5 rst = 0;
    chk("sat_occ0", s_occ, 0);
    cyc();
    chk("sat_latency", s_outValid, 1);
    chk("sat_clkEn", s_clkEn, 0);
    chk("sat_stall0", s_stall, 0);
    cyc();
    chk("sat_stall1", s_stall, 1);
    repeat (4) cyc();
    chk("sat_stall_max", s_stall, 3);
    chk("sat_occ1", s_occ, 1);
    // stream of items 1..8 at full rate
    outReady = 1; first = -1; peak = 0; npop = 0;
    for (int c = 0; c < 12; c++) begin
      inValid = (next_in <= 8);
      if (outValid && first < 0) first = c;
      if (occupancy > peak) peak = occupancy;
      cyc();
    end
    chk("stream_latency", first, 4);
    chk("stream_pops", npop, 8);
    chk("stream_peak", peak, 4);
    chk("stream_stall", stallCount, 0);
    chk("stream_occ_end", occupancy, 0);
    // backpressure on a full pipe
    inValid = 1;
    repeat (4) cyc();
    chk("bp_full", occupancy, 4);
    outReady = 0;
    #1;
    chk("bp_clkEn", clkEn, 0);
    chk("bp_inReady", inReady, 0);
    repeat (5) cyc();
    chk("bp_occ_held", occupancy, 4);
    chk("bp_stall", stallCount, 5);
    outReady = 1; inValid = 0; npop = 0;
    repeat (4) cyc();
    chk("bp_pops", npop, 4);
    chk("bp_next", exp_out, 13);
    chk("bp_occ_end", occupancy, 0);
    chk("bp_stall_kept", stallCount, 5);
    // simultaneous accept and pop on a full pipe
    inValid = 1;
    repeat (4) cyc();
    npop = 0;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("sim_occ", occupancy, 4);
      chk("sim_both", inReady && outValid, 1);
      cyc();
    end
    chk("sim_pops", npop, 4);
    inValid = 0;
    repeat (4) cyc();
    chk("sim_next", exp_out, 21);
    // flush with three items in flight
    inValid = 1;
    repeat (3) cyc();
    chk("fl_occ3", occupancy, 3);
    flushReq = 1;
    #1;
    chk("fl_inReady_same", inReady, 0);
    cyc();
    flushReq = 0;
    chk("fl_draining", draining, 1);
    chk("fl_inReady_drain", inReady, 0);
    inValid = 0; nd = 0; nf = 0; npop = 0;
    for (int c = 0; c < 6; c++) begin
      nd += int'(draining);
      nf += int'(flushDone);
      cyc();
    end
    chk("fl_drain_cycles", nd, 3);
    chk("fl_done_pulses", nf, 1);
    chk("fl_pops", npop, 3);
    chk("fl_next", exp_out, 24);
    chk("fl_run", inReady, 1);
    chk("fl_occ_end", occupancy, 0);
    // flush with an empty pipe
    flushReq = 1;
    #1;
    chk("fe_inReady", inReady, 0);
    cyc();
    flushReq = 0;
    chk("fe_draining", draining, 1);
    chk("fe_done_early", flushDone, 0);
    cyc();
    chk("fe_drain_off", draining, 0);
    chk("fe_done", flushDone, 1);
    cyc();
    chk("fe_done_off", flushDone, 0);
    chk("fe_run", inReady, 1);
    // reset mid-operation with two stalled items
    inValid = 1; outReady = 1;
    repeat (2) cyc();
    inValid = 0; outReady = 0;
    repeat (4) cyc();
    chk("mr_stall", stallCount, 7);
    chk("mr_occ", occupancy, 2);
    chk("mr_clkEn", clkEn, 0);
    #1 rst = 1;
    #1;
    chk("mr_outValid", outValid, 0);
    chk("mr_occ0", occupancy, 0);
    chk("mr_stall0", stallCount, 0);
    chk("mr_clkEn1", clkEn, 1);
    chk("mr_inReady", inReady, 0);
    chk("mr_flushDone", flushDone, 0);
    #2 rst = 0;
    exp_out = next_in;
    outReady = 1; inValid = 1; npop = 0;
    repeat (2) cyc();
    inValid = 0;
    repeat (6) cyc();
    chk("mr_resume_pops", npop, 2);
    chk("mr_resume_occ", occupancy, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/enabled_pipe_controller.md
Name: enabled_pipe_controller

Overview:
Flow-control sequencer for a stallable datapath built from enabledShiftRegister stages of depth CYCLES. It owns the per-stage valid bits and generates the shared clkEn for the datapath, so the datapath freezes as one unit under output backpressure. It provides a valid/ready handshake on both sides, an occupancy count, a drain (flush) sequence and a saturating stall counter. It sits beside the datapath pipe; the datapath carries payload only.

Parameters:
CYCLES, 4, datapath depth in enabled stages; legal range 1..64, and CYCLES=0 is a compile-time error
OCC_W, $clog2(CYCLES+1), occupancy width (derived, not overridden)
STALL_W, 32, stall counter width

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
inValid  in  1  upstream item offered
inReady  out  1  upstream item accepted this cycle if inValid
outValid  out  1  item present at datapath output (= V[CYCLES-1])
outReady  in  1  downstream accepts output item
clkEn  out  1  enable to every datapath enabledShiftRegister stage
occupancy  out  OCC_W  number of valid items in flight
flushReq  in  1  request drain (level sampled)
draining  out  1  high while in DRAIN state
flushDone  out  1  one-cycle pulse when drain completes
stallCount  out  STALL_W  saturating count of backpressure cycles

Behaviour:
- One clock (clk); rst is asynchronous, active-high. All state is cleared on assertion; release is synchronous to clk.
- Reset values: V[*]=0, occupancy=0, state=RUN, flushDone=0, stallCount=0. Hence outValid=0 and clkEn=1. inReady is forced to 0 while rst is high.
- clkEn = ~outValid | outReady (combinational). When clkEn=0, all valid bits and the datapath hold.
- inReady = clkEn & (state==RUN) & ~rst.
- accept = inValid & inReady. pop = outValid & outReady.
- On clkEn: V[0] <= accept, and V[i] <= V[i-1] for i=1..CYCLES-1.
- Latency: an item accepted at cycle t appears on outValid after exactly CYCLES enabled cycles. Full-rate throughput of 1 item/cycle with no bubbles while outReady=1.
- occupancy <= occupancy + accept - pop. Simultaneous accept and pop leaves it unchanged. It must equal popcount(V) at all times (assertion).
- Bubbles are not collapsed: a full stall freezes bubbles in place.
- FSM:
  - RUN -> DRAIN when flushReq=1.
  - DRAIN: inReady=0 and draining=1; the pipe keeps shifting under clkEn.
  - DRAIN -> DONE when registered occupancy==0, or when occupancy==1 and pop occurs this cycle.
  - DONE: flushDone=1 for one cycle, then -> RUN unconditionally.
  - flushReq is ignored in DRAIN and DONE. If flushReq is still high in RUN after DONE, the controller re-enters DRAIN.
  - flushReq with an empty pipe gives one DRAIN cycle, then DONE.
  - inReady is 0 in the same cycle flushReq is sampled in RUN (flushReq gates acceptance combinationally).
- stallCount increments every cycle with outValid & ~outReady and saturates at all-ones. It is cleared only by rst.
- Reset mid-operation: all in-flight valid bits are discarded; datapath payload is don't-care. No flushDone is produced.
- Datapath stages must be built with enabledShiftRegister using the same CYCLES and the same clkEn. Its own reset is not required.

Test Plan:
- Stream: CYCLES=4, outReady=1, inValid=1 for items 1..8 -> outValid first high 4 cycles after first accept; 8 consecutive outputs in order; occupancy peaks at 4; stallCount=0.
- Backpressure: fill 4 items, then outReady=0 for 5 cycles -> clkEn=0, inReady=0, occupancy held at 4, stallCount=5. Release -> items drain in order with no loss or duplication.
- Simultaneous: full pipe, inValid=1, outReady=1 -> accept and pop every cycle, occupancy constant at 4.
- Flush: 3 items in flight, pulse flushReq -> inReady=0 from that cycle; draining high until last pop; flushDone is a single pulse; state returns to RUN; occupancy=0.
- Flush when empty: flushReq pulse with occupancy=0 -> draining for 1 cycle, flushDone on the next cycle.
- Reset mid-op: assert rst asynchronously with 2 items in flight and outReady=0 -> outValid, occupancy and stallCount go to 0 immediately, clkEn=1; after release, accepts resume normally.
